// File: rtl/beat_pkg.sv
// -----------------------------------------------------------------------------
// beat_pkg
// Shared definitions for the beat write responder:
//   - default widths for ID, address, data and register count
//   - packed request/response beat layouts (id in the MSBs)
//   - response codes RESP_OKAY / RESP_SLVERR
//   - FSM state encoding for the single-outstanding build
// -----------------------------------------------------------------------------
package beat_pkg;

  localparam int ID_WIDTH_DEF   = 3;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } req_beat_t;

  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0] id;
    logic [1:0]              resp;
  } rsp_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/beat_wr_responder_if.sv
// -----------------------------------------------------------------------------
// beat_wr_responder_if
// Groups the request and response handshake signals of the beat write
// responder so an environment can carry them as one bundle.
//   master : drives req_data/req_valid and rsp_ready
//   slave  : drives req_ready and rsp_data/rsp_valid
// -----------------------------------------------------------------------------
interface beat_wr_responder_if
  import beat_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] req_data;
  logic                                      req_valid;
  logic                                      req_ready;
  logic [ID_WIDTH+1:0]                       rsp_data;
  logic                                      rsp_valid;
  logic                                      rsp_ready;

  modport master (
    output req_data, req_valid, rsp_ready,
    input  req_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  req_data, req_valid, rsp_ready,
    output req_ready, rsp_data, rsp_valid
  );

endinterface

// File: rtl/beat_resp_fifo.sv
// -----------------------------------------------------------------------------
// beat_resp_fifo
// Two-entry response buffer used by the pipelined responder build.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write a response beat
//   pop_i           : retire the head entry
//   data_o, valid_o : head entry and non-empty flag
//   count_next_o    : occupancy after the coming edge (feeds registered ready)
// Push at full is only honoured together with a pop; pop when empty is ignored.
// -----------------------------------------------------------------------------
module beat_resp_fifo #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_next_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign valid_o      = (count_q != 2'd0);
  assign count_next_o = count_d;

endmodule

// File: rtl/beat_wr_responder.sv
// -----------------------------------------------------------------------------
// beat_wr_responder
// Accepts write request beats {id, addr, data}, writes word-aligned in-range
// addresses into a small register file and answers every request with a
// {id, resp} beat one cycle after acceptance, in acceptance order.
// Ports:
//   aclk, areset_n             : clock, asynchronous active-low reset
//   req_data_i/valid_i/ready_o : request channel
//   rsp_data_o/valid_o/ready_i : response channel
//   rd_idx_i, rd_data_o        : combinational debug read of the register file
// Build option:
//   BEAT_RESP_FIFO_EN undefined : two-state FSM, one outstanding response
//   BEAT_RESP_FIFO_EN defined   : two-entry response FIFO, one request/cycle
// req_ready_o is always a flop output, so it never depends on this cycle's
// req_valid_i or rsp_ready_i.
// -----------------------------------------------------------------------------
module beat_wr_responder
  import beat_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF
) (
  input  logic                                      aclk,
  input  logic                                      areset_n,
  input  logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] req_data_i,
  input  logic                                      req_valid_i,
  output logic                                      req_ready_o,
  output logic [ID_WIDTH+1:0]                       rsp_data_o,
  output logic                                      rsp_valid_o,
  input  logic                                      rsp_ready_i,
  input  logic [$clog2(NUM_REGS)-1:0]               rd_idx_i,
  output logic [DATA_WIDTH-1:0]                     rd_data_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int RSP_W = ID_WIDTH + 2;

  // OKAY only for word-aligned addresses inside the register window.
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
    if ((addr[1:0] == 2'b00) && ((addr >> (IDX_W + 2)) == '0)) begin
      return RESP_OKAY;
    end
    return RESP_SLVERR;
  endfunction

  logic [ID_WIDTH-1:0]   req_id;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            rsp_code;
  logic [RSP_W-1:0]      rsp_new;
  logic                  accept;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic                  ready_q;
  logic                  ready_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  assign req_id    = req_data_i[ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1 -: ID_WIDTH];
  assign req_addr  = req_data_i[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
  assign req_wdata = req_data_i[DATA_WIDTH-1:0];

  assign rsp_code = decode_resp(req_addr);
  assign rsp_new  = {req_id, rsp_code};
  assign accept   = req_valid_i && ready_q;
  assign wr_en    = accept && (rsp_code == RESP_OKAY);
  assign wr_idx   = req_addr[IDX_W+1:2];

  // ---- register file: written on the accepting edge ----
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= req_wdata;
    end
  end

  assign rd_data_o = regs_q[rd_idx_i];

  // ---- request ready: low in reset, rises on the first edge after it ----
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign req_ready_o = ready_q;

`ifdef BEAT_RESP_FIFO_EN

  logic             retire;
  logic             fifo_valid;
  logic [RSP_W-1:0] fifo_head;
  logic [1:0]       fifo_count_d;

  assign retire = fifo_valid && rsp_ready_i;

  beat_resp_fifo #(
    .WIDTH (RSP_W)
  ) u_resp_fifo (
    .clk_i        (aclk),
    .rst_ni       (areset_n),
    .push_i       (accept),
    .data_i       (rsp_new),
    .pop_i        (retire),
    .data_o       (fifo_head),
    .valid_o      (fifo_valid),
    .count_next_o (fifo_count_d)
  );

  // Ready for the next cycle whenever the FIFO will not be full.
  assign ready_d     = (fifo_count_d != 2'd2);
  assign rsp_valid_o = fifo_valid;
  assign rsp_data_o  = fifo_head;

`else

  state_e           state_q;
  state_e           state_d;
  logic [RSP_W-1:0] rsp_q;
  logic [RSP_W-1:0] rsp_d;

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
          rsp_d   = rsp_new;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_q;

`endif

endmodule

// File: tb/tb_beat_wr_responder.sv
// -----------------------------------------------------------------------------
// tb_beat_wr_responder
// Scoreboard bench for beat_wr_responder. Accepted requests push their
// expected response into a queue and update a register-array model; a
// monitor pops and compares on every response handshake. Honours
// BEAT_RESP_FIFO_EN for the build-dependent expectations.
// -----------------------------------------------------------------------------
module tb_beat_wr_responder;
  import beat_pkg::*;

  localparam int IW = ID_WIDTH_DEF;
  localparam int AW = ADDR_WIDTH_DEF;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int NR = NUM_REGS_DEF;
  localparam int XW = $clog2(NR);

  logic          aclk     = 1'b0;
  logic          areset_n = 1'b0;
  logic [XW-1:0] rd_idx   = '0;
  logic [DW-1:0] rd_data;

  int unsigned   cyc      = 0;
  int            tests    = 0;
  int            fails    = 0;
  bit            rand_rdy = 1'b0;

  logic [IW+1:0] exp_q [$];
  logic [IW-1:0] log_id [$];
  int unsigned   log_cyc [$];
  logic [DW-1:0] model [NR];

  beat_wr_responder_if #(
    .ID_WIDTH   (IW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) bus ();

  beat_wr_responder #(
    .ID_WIDTH   (IW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .req_data_i  (bus.req_data),
    .req_valid_i (bus.req_valid),
    .req_ready_o (bus.req_ready),
    .rsp_data_o  (bus.rsp_data),
    .rsp_valid_o (bus.rsp_valid),
    .rsp_ready_i (bus.rsp_ready),
    .rd_idx_i    (rd_idx),
    .rd_data_o   (rd_data)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #10000;
    $display("FAIL timeout: run reached 10000 ns, required: finish earlier");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Response rule: word-aligned and below NR words -> OKAY, else SLVERR.
  function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
    if ((addr % 4 == 0) && (64'(addr) < 64'(NR * 4))) return RESP_OKAY;
    return RESP_SLVERR;
  endfunction

  task automatic note_accept(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
    logic [1:0] r;
    r = exp_resp(addr);
    exp_q.push_back({id, r});
    if (r == RESP_OKAY) model[int'(addr / 4)] = data;
  endtask

  // Called between a rising edge and the next falling edge; returns at
  // rising edge + 1 after the accepting edge.
  task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    bit done;
    done = 1'b0;
    bus.req_data  = {id, addr, data};
    bus.req_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge aclk);
      if (bus.req_ready) begin
        note_accept(id, addr, data);
        done = 1'b1;
      end
      @(posedge aclk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: id %0d not accepted within 50 cycles, required accepted", id);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 40) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      rd_idx = XW'(i);
      #2;
      check($sformatf("%s_reg%0d", tag, i), 64'(rd_data), 64'(model[i]));
      @(posedge aclk);
      #1;
    end
  endtask

  // Monitor: a handshake seen before an edge retires on that edge.
  always @(negedge aclk) begin
    if (areset_n && bus.rsp_valid && bus.rsp_ready) begin
      log_id.push_back(bus.rsp_data[IW+1:2]);
      log_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got 0x%0h, required no response", bus.rsp_data);
      end else begin
        check("rsp_beat", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge aclk) begin
    #1;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int            acc;
    bit            pend;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(negedge aclk);
    check("ready_before_first_edge", 64'(bus.req_ready), 64'd0);
    @(posedge aclk);
    #1;
    check("ready_after_first_edge", 64'(bus.req_ready), 64'd1);
    check_regs("rst");

    // Basic write: id 1, addr 0x4, data 0xA5
    send(3'd1, 32'h4, 32'hA5);
    check("wr1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("wr1_rsp_data", 64'(bus.rsp_data), 64'({3'd1, 2'b00}));
    rd_idx = 3'd1;
    #1;
    check("wr1_rd_data", 64'(rd_data), 64'hA5);
    drain();

    // Error decodes: misaligned and out of range
    send(3'd2, 32'h6, 32'h1111);
    check("misaligned_rsp", 64'(bus.rsp_data), 64'({3'd2, 2'b10}));
    send(3'd3, 32'h20, 32'h2222);
    check("out_of_range_rsp", 64'(bus.rsp_data), 64'({3'd3, 2'b10}));
    drain();
    check_regs("err");

    // Stalled response
    bus.rsp_ready = 1'b0;
    send(3'd5, 32'h8, 32'h5A5A);
    acc = 0;
    bus.req_data = {3'd6, 32'hC, 32'h6B6B};
`ifdef BEAT_RESP_FIFO_EN
    bus.req_valid = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check($sformatf("stall_rsp_data%0d", k), 64'(bus.rsp_data), 64'({3'd5, 2'b00}));
      check($sformatf("stall_rsp_valid%0d", k), 64'(bus.rsp_valid), 64'd1);
`ifndef BEAT_RESP_FIFO_EN
      check($sformatf("stall_req_ready%0d", k), 64'(bus.req_ready), 64'd0);
`endif
      pend = bus.req_valid && bus.req_ready;
      if (pend) begin
        acc++;
        note_accept(3'd6, 32'hC, 32'h6B6B);
      end
      @(posedge aclk);
      #1;
      if (pend) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
`ifdef BEAT_RESP_FIFO_EN
    check("stall_accepts", 64'(acc), 64'd1);
`else
    check("stall_accepts", 64'(acc), 64'd0);
`endif
    bus.rsp_ready = 1'b1;
    drain();
    check_regs("stall");

    // Back-to-back ids 4,5,6
    log_id.delete();
    log_cyc.delete();
    send(3'd4, 32'h0, 32'h4444);
    send(3'd5, 32'h1C, 32'h5555);
    send(3'd6, 32'h40, 32'h6666);
    drain();
    check("b2b_count", 64'(log_id.size()), 64'd3);
    if (log_id.size() == 3) begin
      check("b2b_id0", 64'(log_id[0]), 64'd4);
      check("b2b_id1", 64'(log_id[1]), 64'd5);
      check("b2b_id2", 64'(log_id[2]), 64'd6);
`ifdef BEAT_RESP_FIFO_EN
      check("b2b_gap01", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
      check("b2b_gap12", 64'(log_cyc[2] - log_cyc[1]), 64'd1);
`else
      check("b2b_gap01", 64'(log_cyc[1] - log_cyc[0]), 64'd2);
      check("b2b_gap12", 64'(log_cyc[2] - log_cyc[1]), 64'd2);
`endif
    end

    // Reset while a response is pending
    bus.rsp_ready = 1'b0;
    send(3'd7, 32'h10, 32'h77);
    check("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
    #2;
    areset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge aclk);
    #1;
    areset_n      = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge aclk);
    check("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge aclk);
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);
    check("post_rst_valid2", 64'(bus.rsp_valid), 64'd0);
    check_regs("post_rst");

    // Randomized traffic with random response back-pressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 100; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
      id   = IW'($urandom_range(0, (1 << IW) - 1));
      data = $urandom;
      case ($urandom_range(0, 4))
        0, 1, 2: addr = AW'($urandom_range(0, NR - 1) * 4);
        3:       addr = AW'($urandom_range(0, NR * 4 - 1)) | 32'h1;
        default: addr = ($urandom | 32'(NR * 4)) & ~32'h3;
      endcase
      send(id, addr, data);
      if (t % 10 == 9) begin
        rd_idx = XW'($urandom_range(0, NR - 1));
        #1;
        check("rand_rd", 64'(rd_data), 64'(model[rd_idx]));
      end
    end
    rand_rdy = 1'b0;
    @(posedge aclk);
    #3;
    bus.rsp_ready = 1'b1;
    drain();
    check_regs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
